pkt_frame_buffer: RTL and testbench
===================================

// Module: pkt_frame_buffer
// PURPOSE
// - Ingress stage fed directly by the packet source (pkt_data_in/pkt_ctl_in beat stream, 512b/beat).
// - Checks framing, stores beats store-and-forward; only complete, well-formed packets become visible downstream.
// - Replays committed packets to the parser/match stage over a valid/ready interface with SOP/EOP flags.
// PARAMETERS
// - DATA_W     512  beat width in bits
// - DEPTH      64   beat buffer entries (power of 2)
// - MAX_BEATS  32   longest legal packet in beats; longer is dropped
// - CNT_W      32   statistics counter width
// PORTS
// - clk            in   1       clock
// - reset          in   1       synchronous, active-high
// - pkt_data_in    in   DATA_W  beat data
// - pkt_ctl_in     in   8       0=idle 1=SOP 2=middle 3=EOP 4=single-beat pkt; 5..255 illegal
// - in_rdy         out  1       free entries >= MAX_BEATS (advisory; source has no backpressure)
// - out_data       out  DATA_W  head beat
// - out_sop        out  1       head beat starts packet
// - out_eop        out  1       head beat ends packet
// - out_valid      out  1       head beat valid
// - out_ready      in   1       consumer accepts beat when out_valid&&out_ready
// - pkt_cnt        out  CNT_W   packets committed
// - drop_cnt       out  CNT_W   packets dropped (overflow / too long)
// - err_cnt        out  CNT_W   framing errors
// BEHAVIOUR
// - Reset: all outputs 0 except in_rdy=1; pointers, FSM, counters cleared; reset mid-packet discards all state.
// - Pointers wr_ptr (tentative), commit_ptr, rd_ptr, each log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
// - free = DEPTH-(wr_ptr-rd_ptr); a beat writes only if free>=1; reader sees only rd_ptr..commit_ptr.
// - Entry = {sop,eop,data}. ctl=0 beats ignored in every state (gaps legal anywhere).
// - Ingress FSM IDLE/IN_PKT/DROP; len counts beats of current packet:
//   IDLE: 1 -> write(sop), len=1, IN_PKT (no space -> DROP). 4 -> write(sop,eop), commit,
//         pkt_cnt++ (no space -> drop_cnt++). 2,3,illegal -> err_cnt++, stay.
//   IN_PKT: 2 -> write, len++; no space or len==MAX_BEATS -> wr_ptr=commit_ptr, DROP.
//           3 -> write(eop), commit_ptr=wr_ptr+1, pkt_cnt++, IDLE; no space/too long ->
//           rollback, drop_cnt++, IDLE. 1/4 -> rollback, err_cnt++, then handle as in IDLE same cycle.
//           illegal -> rollback, err_cnt++, IDLE.
//   DROP: 2 ignored; 3 -> drop_cnt++, IDLE; 1/4 -> drop_cnt++, handle as IDLE same cycle; illegal -> err_cnt++, IDLE.
// - Egress: FWFT; RAM read latency 1 hidden by output register + 1-entry prefetch; sustains 1 beat/clk.
// - Latency: EOP/single beat at clk t -> out_valid at t+2 earliest (empty buffer).
// - out_* stable while out_valid&&!out_ready; simultaneous write/commit and read legal.
// - Freed entries counted in free the cycle after the read; commit of full buffer (free=0) legal.
// - Counters wrap at 2^CNT_W.
// STRUCTURE
// - pkt_pkg: CTL_IDLE/SOP/MID/EOP/SINGLE localparams, ingress state enum, entry struct.
// - Sub-module pkt_beat_ram: 1W1R simple dual-port, DEPTH x (DATA_W+2), registered read.
// - Top: ingress FSM + pointers, egress prefetch/output regs, counters.
// TESTING
// - Single: ctl 4 with data 'hA5 -> 1 beat out sop=eop=1 data 'hA5, pkt_cnt=1, 2 clk after.
// - 2-beat pkt 1,0,3 with gaps, out_ready=1 -> beats in order sop then eop, nothing before EOP commit.
// - Framing: 3 in IDLE -> err_cnt=1, no output; 1,2,1,3 -> first pkt discarded, err_cnt=1, 2-beat pkt out.
// - Overflow: out_ready=0, DEPTH=64, send two 32-beat pkts then third -> third dropped, drop_cnt=1, 64 beats out in order.
// - Too long: 33-beat pkt -> drop_cnt=1, pkt_cnt unchanged, next single beat passes.
// - Backpressure: toggle out_ready randomly -> out_* held while stalled, no beat lost or duplicated; reset mid-pkt -> all cleared.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared constants and types for the packet ingress frame buffer.
// Beat control codes, ingress FSM states and the stored entry layout.
package pkt_pkg;

  localparam int BEAT_W = 512;

  localparam logic [7:0] CTL_IDLE   = 8'd0;
  localparam logic [7:0] CTL_SOP    = 8'd1;
  localparam logic [7:0] CTL_MID    = 8'd2;
  localparam logic [7:0] CTL_EOP    = 8'd3;
  localparam logic [7:0] CTL_SINGLE = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT,
    ST_DROP
  } ing_state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [BEAT_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/pkt_beat_ram.sv
// Simple dual-port beat store: one write port, one read port
// with a registered read (data valid the cycle after re).
module pkt_beat_ram #(
  parameter int W     = 514,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_frame_buffer.sv
// Store-and-forward ingress buffer: framing check, tentative write,
// commit on EOP, FWFT replay of committed beats with SOP/EOP flags.
module pkt_frame_buffer
  import pkt_pkg::*;
#(
  parameter int DATA_W    = BEAT_W,
  parameter int DEPTH     = 64,
  parameter int MAX_BEATS = 32,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pkt_data_in,
  input  logic [7:0]        pkt_ctl_in,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_BEATS + 1);

  typedef logic [PW-1:0] ptr_t;

  ing_state_t      st, st_n;
  ptr_t            wr_ptr, commit_ptr, rd_ptr;
  ptr_t            wp_n, cp_n, wa, used, used_c;
  logic [LW-1:0]   len, len_n;
  logic            we, space, space_c, from_idle;
  logic            inc_pkt, inc_drop, inc_err;
  logic            is_start, is_mid, is_eop, is_bad;
  entry_t          wd, q, ob, pf;
  logic            ov, pv, rv, pop, issue;

  assign used    = wr_ptr - rd_ptr;
  assign used_c  = commit_ptr - rd_ptr;
  assign space   = used < ptr_t'(DEPTH);
  assign space_c = used_c < ptr_t'(DEPTH);
  assign in_rdy  = (ptr_t'(DEPTH) - used) >= ptr_t'(MAX_BEATS);

  assign is_start = (pkt_ctl_in == CTL_SOP) || (pkt_ctl_in == CTL_SINGLE);
  assign is_mid   = pkt_ctl_in == CTL_MID;
  assign is_eop   = pkt_ctl_in == CTL_EOP;
  assign is_bad   = pkt_ctl_in > CTL_SINGLE;

  always_comb begin
    st_n      = st;
    wp_n      = wr_ptr;
    cp_n      = commit_ptr;
    len_n     = len;
    we        = 1'b0;
    wa        = wr_ptr;
    wd.sop    = 1'b0;
    wd.eop    = 1'b0;
    wd.data   = pkt_data_in;
    inc_pkt   = 1'b0;
    inc_drop  = 1'b0;
    inc_err   = 1'b0;
    from_idle = 1'b0;
    unique case (st)
      ST_IDLE: from_idle = 1'b1;
      ST_IN_PKT: begin
        unique case (1'b1)
          is_mid: begin
            if (!space || len == LW'(MAX_BEATS)) begin
              wp_n = commit_ptr;
              st_n = ST_DROP;
            end else begin
              we    = 1'b1;
              wp_n  = wr_ptr + 1'b1;
              len_n = len + 1'b1;
            end
          end
          is_eop: begin
            st_n = ST_IDLE;
            if (!space || len == LW'(MAX_BEATS)) begin
              wp_n     = commit_ptr;
              inc_drop = 1'b1;
            end else begin
              we      = 1'b1;
              wd.eop  = 1'b1;
              wp_n    = wr_ptr + 1'b1;
              cp_n    = wr_ptr + 1'b1;
              inc_pkt = 1'b1;
            end
          end
          is_start: begin
            wp_n      = commit_ptr;
            inc_err   = 1'b1;
            from_idle = 1'b1;
          end
          is_bad: begin
            wp_n    = commit_ptr;
            inc_err = 1'b1;
            st_n    = ST_IDLE;
          end
          default: ;
        endcase
      end
      ST_DROP: begin
        unique case (1'b1)
          is_eop: begin
            inc_drop = 1'b1;
            st_n     = ST_IDLE;
          end
          is_start: begin
            inc_drop  = 1'b1;
            from_idle = 1'b1;
          end
          is_bad: begin
            inc_err = 1'b1;
            st_n    = ST_IDLE;
          end
          default: ;
        endcase
      end
      default: st_n = ST_IDLE;
    endcase
    // Outside a packet wr_ptr equals commit_ptr, so new packets start there.
    if (from_idle) begin
      unique case (1'b1)
        pkt_ctl_in == CTL_SOP: begin
          wp_n = commit_ptr;
          st_n = ST_DROP;
          if (space_c) begin
            we     = 1'b1;
            wa     = commit_ptr;
            wd.sop = 1'b1;
            wp_n   = commit_ptr + 1'b1;
            len_n  = LW'(1);
            st_n   = ST_IN_PKT;
          end
        end
        pkt_ctl_in == CTL_SINGLE: begin
          wp_n = commit_ptr;
          st_n = ST_IDLE;
          if (space_c) begin
            we      = 1'b1;
            wa      = commit_ptr;
            wd.sop  = 1'b1;
            wd.eop  = 1'b1;
            wp_n    = commit_ptr + 1'b1;
            cp_n    = commit_ptr + 1'b1;
            inc_pkt = 1'b1;
          end else begin
            inc_drop = 1'b1;
          end
        end
        is_mid || is_eop || is_bad: begin
          inc_err = 1'b1;
          st_n    = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      st         <= st_n;
      wr_ptr     <= wp_n;
      commit_ptr <= cp_n;
      len        <= len_n;
      pkt_cnt    <= pkt_cnt + CNT_W'(inc_pkt);
      drop_cnt   <= drop_cnt + CNT_W'(inc_drop);
      err_cnt    <= err_cnt + CNT_W'(inc_err);
    end
  end

  pkt_beat_ram #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wa[AW-1:0]),
    .wdata (wd),
    .re    (issue),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (q)
  );

  // Issue a read only if its data is sure to find a free slot on arrival.
  assign pop   = ov && out_ready;
  assign issue = (rd_ptr != commit_ptr) &&
                 (({1'b0, ov} + {1'b0, pv} + {1'b0, rv}) <= ({1'b0, pop} + 2'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      rv     <= 1'b0;
      pv     <= 1'b0;
      ov     <= 1'b0;
      pf     <= '0;
      ob     <= '0;
    end else begin
      rv <= issue;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (!ov || pop) begin
        if (pv) begin
          ob <= pf;
          ov <= 1'b1;
          pv <= rv;
          if (rv) pf <= q;
        end else if (rv) begin
          ob <= q;
          ov <= 1'b1;
        end else begin
          ov <= 1'b0;
        end
      end else if (rv) begin
        pf <= q;
        pv <= 1'b1;
      end
    end
  end

  assign out_valid = ov;
  assign out_sop   = ob.sop;
  assign out_eop   = ob.eop;
  assign out_data  = ob.data;

endmodule

// File: tb/tb_pkt_frame_buffer.sv
// Bench for pkt_frame_buffer: directed framing/overflow cases and random
// backpressure traffic checked against a packet-level expected-beat queue.
`timescale 1ns/1ps
module tb_pkt_frame_buffer;
  import pkt_pkg::*;

  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int CW    = 32;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [7:0]    ctl_in = '0;
  logic          in_rdy, out_sop, out_eop, out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pkt_cnt, drop_cnt, err_cnt;

  logic rdy_fix = 1'b0;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b0;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  pkt_frame_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_data_in (data_in),
    .pkt_ctl_in  (ctl_in),
    .in_rdy      (in_rdy),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  assign out_ready = rnd_mode ? rnd_bit : rdy_fix;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Consumer side: every accepted beat must be the next expected one,
  // and a stalled head must hold still.
  logic  stalled = 1'b0;
  beat_t held, mon_e, mon_g;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      mon_g = {out_sop, out_eop, out_data};
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || mon_g !== held) begin
          errors++;
          $display("FAIL hold_stable: got v=%b sop=%b eop=%b d=%h, want v=1 sop=%b eop=%b d=%h",
                   out_valid, out_sop, out_eop, out_data[31:0], held.sop, held.eop, held.data[31:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got sop=%b eop=%b d=%h, want no beat",
                   out_sop, out_eop, out_data[31:0]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_g !== mon_e) begin
            errors++;
            $display("FAIL beat_order: got sop=%b eop=%b d=%h, want sop=%b eop=%b d=%h",
                     out_sop, out_eop, out_data[31:0], mon_e.sop, mon_e.eop, mon_e.data[31:0]);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = mon_g;
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic idle(input int n);
    ctl_in = CTL_IDLE;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] c, input logic [DW-1:0] d);
    ctl_in  = c;
    data_in = d;
    @(posedge clk);
    #1;
    ctl_in = CTL_IDLE;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ctl_in = CTL_IDLE;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Sends a well-formed packet; if ok, its beats are expected downstream.
  task automatic send_pkt(input int len, input int gap, input bit ok);
    beat_t pk[$];
    logic [7:0] c;
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.sop  = (i == 0);
      x.eop  = (i == len - 1);
      x.data = rnd_data();
      pk.push_back(x);
      if (len == 1) c = CTL_SINGLE;
      else if (i == 0) c = CTL_SOP;
      else if (i == len - 1) c = CTL_EOP;
      else c = CTL_MID;
      beat(c, x.data);
      if (i == len - 1 && ok) begin
        foreach (pk[k]) exp_q.push_back(pk[k]);
      end
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) idle(1);
    idle(3);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL rst_sop: got %b want 0", out_sop); end
    checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b want 0", out_eop); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data[31:0]); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b want 1", in_rdy); end
    checks++; if (pkt_cnt !== 0) begin errors++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_single();
    beat_t b;
    do_reset();
    rdy_fix = 1'b1;
    b.sop = 1'b1; b.eop = 1'b1; b.data = DW'(32'hA5);
    exp_q.push_back(b);
    beat(CTL_SINGLE, DW'(32'hA5));
    checks++; if (pkt_cnt !== 1) begin errors++; $display("FAIL single_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early0: got %b want 0", out_valid); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early1: got %b want 0", out_valid); end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_eop !== 1'b1 || out_data !== DW'(32'hA5)) begin
      errors++;
      $display("FAIL single_out: got v=%b sop=%b eop=%b d=%h want 1 1 1 a5",
               out_valid, out_sop, out_eop, out_data[31:0]);
    end
    drain(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_two_beat();
    beat_t b0, b1;
    do_reset();
    rdy_fix = 1'b1;
    b0.sop = 1'b1; b0.eop = 1'b0; b0.data = rnd_data();
    b1.sop = 1'b0; b1.eop = 1'b1; b1.data = rnd_data();
    beat(CTL_SOP, b0.data);
    idle(4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_precommit: got %b want 0", out_valid); end
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    beat(CTL_EOP, b1.data);
    drain(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL two_drain: got %0d left want 0", exp_q.size()); end
    checks++; if (pkt_cnt !== 1) begin errors++; $display("FAIL two_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_framing();
    beat_t c, d;
    do_reset();
    rdy_fix = 1'b1;
    beat(CTL_EOP, rnd_data());
    idle(4);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL frm_eop_err: got %0d want 1", err_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frm_eop_out: got %b want 0", out_valid); end
    beat(8'd9, rnd_data());
    beat(CTL_MID, rnd_data());
    idle(2);
    checks++; if (err_cnt !== 3) begin errors++; $display("FAIL frm_bad_err: got %0d want 3", err_cnt); end
    do_reset();
    c.sop = 1'b1; c.eop = 1'b0; c.data = rnd_data();
    d.sop = 1'b0; d.eop = 1'b1; d.data = rnd_data();
    beat(CTL_SOP, rnd_data());
    beat(CTL_MID, rnd_data());
    beat(CTL_SOP, c.data);
    exp_q.push_back(c);
    exp_q.push_back(d);
    beat(CTL_EOP, d.data);
    drain(20);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL frm_restart_err: got %0d want 1", err_cnt); end
    checks++; if (pkt_cnt !== 1) begin errors++; $display("FAIL frm_restart_pkt: got %0d want 1", pkt_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frm_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_fix = 1'b0;
    send_pkt(32, 0, 1'b1);
    send_pkt(32, 0, 1'b1);
    send_pkt(32, 0, 1'b0);
    idle(2);
    checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    checks++; if (pkt_cnt !== 2) begin errors++; $display("FAIL ovf_pkt: got %0d want 2", pkt_cnt); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL ovf_in_rdy: got %b want 0", in_rdy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_head: got %b want 1", out_valid); end
    rdy_fix = 1'b1;
    drain(300);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d left want 0", exp_q.size()); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL ovf_in_rdy_after: got %b want 1", in_rdy); end
  endtask

  task automatic test_too_long();
    do_reset();
    rdy_fix = 1'b1;
    send_pkt(32, 0, 1'b1);
    send_pkt(33, 0, 1'b0);
    send_pkt(40, 0, 1'b0);
    send_pkt(1, 0, 1'b1);
    drain(200);
    checks++; if (pkt_cnt !== 2) begin errors++; $display("FAIL long_pkt: got %0d want 2", pkt_cnt); end
    checks++; if (drop_cnt !== 2) begin errors++; $display("FAIL long_drop: got %0d want 2", drop_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL long_err: got %0d want 0", err_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL long_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int exp_pkt, exp_err;
    exp_pkt = 0;
    exp_err = 0;
    do_reset();
    rnd_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len, kind, mids;
      len  = $urandom_range(1, 8);
      kind = $urandom_range(0, 7);
      for (int w = 0; w < 2000 && exp_q.size() + len > DEPTH; w++) idle(1);
      checks++;
      if (exp_q.size() + len > DEPTH) begin
        errors++;
        $display("FAIL bp_space_wait: got %0d queued want <= %0d", exp_q.size(), DEPTH - len);
      end
      if (kind == 0) begin
        beat(CTL_MID, rnd_data());
        exp_err++;
      end
      if (kind == 1 && len > 1) begin
        mids = $urandom_range(0, len - 2);
        beat(CTL_SOP, rnd_data());
        repeat (mids) beat(CTL_MID, rnd_data());
        beat(8'($urandom_range(5, 255)), rnd_data());
        exp_err++;
      end else begin
        send_pkt(len, 2, 1'b1);
        exp_pkt++;
      end
    end
    drain(3000);
    rnd_mode = 1'b0;
    rdy_fix  = 1'b1;
    drain(20);
    checks++; if (pkt_cnt !== CW'(exp_pkt)) begin errors++; $display("FAIL bp_pkt: got %0d want %0d", pkt_cnt, exp_pkt); end
    checks++; if (err_cnt !== CW'(exp_err)) begin errors++; $display("FAIL bp_err: got %0d want %0d", err_cnt, exp_err); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL bp_drop: got %0d want 0", drop_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    beat_t s;
    do_reset();
    rdy_fix = 1'b0;
    send_pkt(3, 0, 1'b1);
    beat(CTL_SOP, rnd_data());
    beat(CTL_MID, rnd_data());
    idle(2);
    reset = 1'b1;
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_data: got %h want 0", out_data[31:0]); end
    checks++; if (pkt_cnt !== 0) begin errors++; $display("FAIL rmid_pkt: got %0d want 0", pkt_cnt); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rmid_in_rdy: got %b want 1", in_rdy); end
    reset = 1'b0;
    exp_q.delete();
    rdy_fix = 1'b1;
    beat(CTL_EOP, rnd_data());
    s.sop = 1'b1; s.eop = 1'b1; s.data = rnd_data();
    exp_q.push_back(s);
    beat(CTL_SINGLE, s.data);
    drain(20);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL rmid_err: got %0d want 1", err_cnt); end
    checks++; if (pkt_cnt !== 1) begin errors++; $display("FAIL rmid_pkt_after: got %0d want 1", pkt_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_two_beat();
    test_framing();
    test_overflow();
    test_too_long();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
